// File: rtl/pack2_reg_pkg.sv
// Shared constants and types for the 2-bit base packer.
//   DATA_W/BASE_W/BASES/CNT_W : word geometry and count width
//   BASE_A..BASE_T            : nucleotide encodings
//   FILL/HOLD                 : packer state encodings
//   word_t                    : output word payload (last, count, data)
package pack2_reg_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned BASE_W = 2;
  localparam int unsigned BASES  = DATA_W / BASE_W;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned IDX_W  = $clog2(DATA_W);

  localparam logic [BASE_W-1:0] BASE_A = 2'b00;
  localparam logic [BASE_W-1:0] BASE_C = 2'b01;
  localparam logic [BASE_W-1:0] BASE_G = 2'b10;
  localparam logic [BASE_W-1:0] BASE_T = 2'b11;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  typedef struct packed {
    logic              last;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] data;
  } word_t;

endpackage

// File: rtl/pack2_reg_if.sv
// Base-in / word-out handshake bundle of the packer.
//   base_in/base_valid/base_ready/flush : upstream base stream
//   out_data/out_count/out_last/out_valid/out_ready : packed word stream
//   slave modport  : the packer
//   master modport : the environment driving bases and consuming words
interface pack2_reg_if
  import pack2_reg_pkg::*;
();

  logic [BASE_W-1:0] base_in;
  logic              base_valid;
  logic              base_ready;
  logic              flush;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  base_in, base_valid, flush, out_ready,
    output base_ready, out_data, out_count, out_last, out_valid
  );

  modport master (
    output base_in, base_valid, flush, out_ready,
    input  base_ready, out_data, out_count, out_last, out_valid
  );

endinterface

// File: rtl/pack2_reg.sv
// Packs 2-bit bases LSB-first into 512-bit words (256 bases, or fewer on flush)
// and presents each word on a valid/ready handshake.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, discards partial and pending words
//   bus  : pack2_reg_if.slave (base stream in, packed word stream out)
module pack2_reg
  import pack2_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  pack2_reg_if.slave  bus
);

  logic [0:0]        state_q,     state_d;
  logic [DATA_W-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [CNT_W-1:0]  pend_cnt_q,  pend_cnt_d;
  logic              pend_last_q, pend_last_d;
  word_t             out_q,       out_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic              out_free;
  logic              close;
  logic [CNT_W-1:0]  n;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] merged;

  assign bus.base_ready = (state_q == FILL);
  assign bus.out_data   = out_q.data;
  assign bus.out_count  = out_q.count;
  assign bus.out_last   = out_q.last;
  assign bus.out_valid  = out_valid_q;

  assign accept   = bus.base_valid && (state_q == FILL);
  assign out_free = !out_valid_q || bus.out_ready;
  assign n        = cnt_q + CNT_W'(accept);
  // cnt_q stays below BASES in FILL, so its low bits give the base slot
  assign wr_idx   = IDX_W'({cnt_q[CNT_W-2:0], 1'b0});
  // a word closes on the 256th base or on a flush with at least one base
  assign close    = (accept && (n == CNT_W'(BASES))) || (bus.flush && (n != '0));

  // accumulator with the incoming base already merged in
  always_comb begin
    merged = acc_q;
    if (accept) begin
      merged[wr_idx +: BASE_W] = bus.base_in;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    pend_cnt_d  = pend_cnt_q;
    pend_last_d = pend_last_q;
    out_d       = out_q;
    out_valid_d = out_valid_q && !bus.out_ready;

    case (state_q)
      FILL: begin
        if (accept) begin
          acc_d = merged;
          cnt_d = n;
        end
        if (close) begin
          if (out_free) begin
            out_d       = '{last: bus.flush, count: n, data: merged};
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
          end else begin
            // park the finished word in acc until the output slot frees up
            state_d     = HOLD;
            pend_cnt_d  = n;
            pend_last_d = bus.flush;
            cnt_d       = '0;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          out_d       = '{last: pend_last_q, count: pend_cnt_q, data: acc_q};
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      acc_q       <= '0;
      cnt_q       <= '0;
      pend_cnt_q  <= '0;
      pend_last_q <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      pend_last_q <= pend_last_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pack2_reg.sv
// Randomized scoreboard bench for pack2_reg plus directed checks of the
// reset, full-word, partial-flush, backpressure and edge-flush cases.
module tb_pack2_reg;
  import pack2_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pack2_reg_if bus();

  pack2_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    rx_count = 0;
  bit    rand_rdy = 1'b0;
  word_t last_rx = '0;

  // reference model state: bases collected so far and words still owed
  logic [1:0] cur_q[$];
  word_t      exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic word_t build_word(input bit last);
    word_t w;
    w = '0;
    for (int i = 0; i < cur_q.size(); i++) w.data[2*i +: 2] = cur_q[i];
    w.count = CNT_W'(cur_q.size());
    w.last  = last;
    return w;
  endfunction

  // monitor + model, evaluated mid-cycle ahead of the next rising edge
  bit    stall = 1'b0;
  word_t stall_word;
  always @(negedge clk) begin
    word_t got;
    word_t e;
    got = '{last: bus.out_last, count: bus.out_count, data: bus.out_data};
    if (rst) begin
      cur_q.delete();
      exp_q.delete();
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (!bus.out_valid || got != stall_word) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b cnt=%0d last=%0b, need cnt=%0d last=%0b held",
                   bus.out_valid, got.count, got.last, stall_word.count, stall_word.last);
        end
      end
      stall = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          checks++;
          rx_count++;
          last_rx = got;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got cnt=%0d last=%0b with nothing expected", got.count, got.last);
          end else begin
            e = exp_q.pop_front();
            if (got != e) begin
              errors++;
              $display("FAIL word: got cnt=%0d last=%0b data=%h, need cnt=%0d last=%0b data=%h",
                       got.count, got.last, got.data, e.count, e.last, e.data);
            end
          end
        end else begin
          stall = 1'b1;
          stall_word = got;
        end
      end
      if (bus.base_ready) begin
        if (bus.base_valid) cur_q.push_back(bus.base_in);
        if ((bus.base_valid && cur_q.size() == BASES) || (bus.flush && cur_q.size() > 0)) begin
          exp_q.push_back(build_word(bus.flush));
          cur_q.delete();
        end
      end
    end
  end

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %0h, need %0h", name, got, need);
    end
  endtask

  // present one base (optionally with flush) and hold it until accepted
  task automatic send(input logic [1:0] b, input logic fl);
    int guard;
    guard = 0;
    bus.base_in = b;
    bus.base_valid = 1'b1;
    bus.flush = fl;
    @(negedge clk);
    while (!bus.base_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: base_ready stuck at 0 for %0d cycles, need 1", guard);
    end
    @(posedge clk);
    #1;
    bus.base_valid = 1'b0;
    bus.flush = 1'b0;
    bus.base_in = 2'($urandom);
  endtask

  task automatic flush_only();
    send(2'b00, 1'b1);
  endtask

  task automatic flush_alone();
    int guard;
    guard = 0;
    bus.base_valid = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    while (!bus.base_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout: base_ready stuck at 0, need 1");
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still owed, need 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [511:0] d;
    int c0;
    int r0;
    logic [1:0] pat [4];
    pat[0] = BASE_A; pat[1] = BASE_C; pat[2] = BASE_G; pat[3] = BASE_T;

    // reset with stimulus active
    bus.base_in = BASE_T;
    bus.base_valid = 1'b1;
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.base_valid = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 512'(bus.out_valid), 512'd0);
    check("rst_out_data", bus.out_data, 512'd0);
    check("rst_out_count", 512'(bus.out_count), 512'd0);
    check("rst_base_ready", 512'(bus.base_ready), 512'd1);
    @(posedge clk);
    #1;

    // full word, no bubbles
    c0 = cyc;
    for (int i = 0; i < 256; i++) send(pat[i % 4], 1'b0);
    check("full_rate_cycles", 512'(cyc - c0), 512'd256);
    @(negedge clk);
    d = {64{8'hE4}};
    check("full_valid", 512'(bus.out_valid), 512'd1);
    check("full_data", bus.out_data, d);
    check("full_count", 512'(bus.out_count), 512'd256);
    check("full_last", 512'(bus.out_last), 512'd0);
    @(posedge clk);
    #1;

    // partial flush
    send(BASE_T, 1'b0); send(BASE_T, 1'b0); send(BASE_A, 1'b0);
    send(BASE_C, 1'b0); send(BASE_G, 1'b0);
    flush_alone();
    @(negedge clk);
    d = bus.out_data;
    check("part_valid", 512'(bus.out_valid), 512'd1);
    check("part_low", 512'(d[9:0]), 512'h24F);
    check("part_high", 512'(d[511:10]), 512'd0);
    check("part_count", 512'(bus.out_count), 512'd5);
    check("part_last", 512'(bus.out_last), 512'd1);
    @(posedge clk);
    #1;

    // backpressure into HOLD
    bus.out_ready = 1'b0;
    for (int i = 0; i < 512; i++) send(2'($urandom), 1'b0);
    @(negedge clk);
    check("bp_hold_ready", 512'(bus.base_ready), 512'd0);
    check("bp_hold_valid", 512'(bus.out_valid), 512'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_second_valid", 512'(bus.out_valid), 512'd1);
    check("bp_second_count", 512'(bus.out_count), 512'd256);
    check("bp_ready_back", 512'(bus.base_ready), 512'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // empty flush is a no-op
    r0 = rx_count;
    flush_alone();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("empty_flush_valid", 512'(bus.out_valid), 512'd0);
    end
    @(posedge clk);
    #1;

    // flush together with the 256th base
    for (int i = 0; i < 255; i++) send(2'($urandom), 1'b0);
    send(BASE_G, 1'b1);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;
    check("edge_words", 512'(rx_count - r0), 512'd1);
    check("edge_count", 512'(last_rx.count), 512'd256);
    check("edge_last", 512'(last_rx.last), 512'd1);

    // reset mid-word
    for (int i = 0; i < 100; i++) send(2'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(BASE_A, 1'b0); send(BASE_C, 1'b0); send(BASE_G, 1'b1);
    wait_drain();
    d = last_rx.data;
    check("mid_rst_count", 512'(last_rx.count), 512'd3);
    check("mid_rst_low", 512'(d[5:0]), 512'b100100);
    check("mid_rst_high", 512'(d[511:6]), 512'd0);
    check("mid_rst_last", 512'(last_rx.last), 512'd1);

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: begin @(posedge clk); #1; end
        1: if ($urandom_range(0, 3) == 0) flush_alone(); else send(2'($urandom), 1'b0);
        default: send(2'($urandom), 1'($urandom_range(0, 24) == 0));
      endcase
    end
    flush_alone();
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
    check("final_owed", 512'(exp_q.size()), 512'd0);
    check("final_partial", 512'(cur_q.size()), 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pack2_reg.md
Name: pack2_reg

Overview:
Nucleotide packer and writer side of the 2-bit base stream. Accepts one 2-bit base per cycle and packs 256 bases into a 512-bit word, or fewer on flush. Presents each word with a valid/ready handshake for the 512-bit load/shift-by-2 consumer, which unpacks LSB-first. out_count (9 bits) feeds the consumer's ShiftNo.

Parameters:
DATA_W, 512, packed word width.
BASE_W, 2, bits per base (A=00, C=01, G=10, T=11).
BASES, DATA_W/BASE_W = 256, bases per word.
CNT_W, 9, count width; must hold BASES.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
base_in  in  2  base value.
base_valid  in  1  base_in is valid this cycle.
base_ready  out  1  packer can accept a base or flush this cycle.
flush  in  1  end-of-sequence request; held by upstream until sampled with base_ready=1.
out_data  out  512  packed word; base i at bits [2i+1:2i]; unused positions zero.
out_count  out  9  number of valid bases in out_data, 1..256.
out_last  out  1  word closes a sequence (flush).
out_valid  out  1  out_data/out_count/out_last are valid.
out_ready  in  1  consumer takes the word when out_valid=1.

Behaviour:
- Reset (rst=1 at a clock edge, and it overrides everything): acc=0, cnt=0, state=FILL, out_valid=0, out_data=0, out_count=0, out_last=0. A reset mid-word or mid-hold discards all partial and pending data.
- base_ready=1 iff state==FILL. It is registered-state-derived, so it is 1 immediately after reset.
- Accept: base_valid & base_ready. The base is written to acc[2*cnt +: 2]; cnt increments.
- out_free = !out_valid | out_ready.
- Word close happens in FILL when either (a) the accepted base makes cnt reach 256, or (b) flush=1 with the post-accept count n>0. A base and a flush in the same cycle means the base is included first.
  - If out_free: out_data <= acc merged with the incoming base; out_count <= n; out_last <= flush; out_valid <= 1; acc <= 0; cnt <= 0. Latency is 1 cycle from the closing accept to out_valid. There are no bubbles, so the sustained rate is 1 base/clk.
  - Else: the merged word stays in acc and state -> HOLD, with pending_last = flush and pending_cnt = n.
- HOLD: base_ready=0 and flush is not sampled. On out_free, transfer acc -> out register (count = pending_cnt, last = pending_last), clear acc/cnt, and return to FILL. base_ready=1 on the following cycle.
- out_valid stays high with stable data until out_valid & out_ready. If out_valid & out_ready and no new close occurs that cycle, out_valid <= 0.
- Flush with n==0 (empty accumulator, no base that cycle) is a no-op: no word and no out_last. Upstream sends no empty terminating word.
- Flush arriving together with the 256th base: a single word with out_count=256 and out_last=1.
- cnt never exceeds 256. Its value 256 is never held, because the word closes in the same cycle.
- base_in is ignored when base_valid=0. base_valid while base_ready=0 is not accepted; upstream holds it.

Decomposition:
- Shared package: DATA_W, BASE_W, BASES, CNT_W; base encoding constants BASE_A/C/G/T; state enum {FILL, HOLD}.
- Single module, no sub-module. The indexed base write is the only non-trivial datapath, and it stays inline.

Test Plan:
1. Reset: rst high 2 cycles, stimulus active -> out_valid=0, out_data=0, out_count=0, base_ready=1 on the first cycle after reset.
2. Full word: 256 bases in pattern A,C,G,T repeating, out_ready=1 -> one cycle after the 256th accept, out_valid=1, out_data = every byte 8'hE4, out_count=256, out_last=0; base_ready never drops.
3. Partial flush: bases T,T,A,C,G then flush -> out_data[9:0]=10'h24F, out_data[511:10]=0, out_count=5, out_last=1.
4. Backpressure: out_ready=0, stream 512 bases -> first word held stable. After the 512th accept, state=HOLD and base_ready=0. Raise out_ready for 1 cycle -> second word appears next cycle and base_ready returns to 1.
5. Edge flushes: flush with empty acc -> no out_valid. Flush on the same cycle as the 256th base -> one word with out_count=256 and out_last=1, and no extra empty word.
6. Reset mid-word: 100 bases, rst 1 cycle, then 3 bases A,C,G + flush -> out_count=3, out_data[5:0]=6'b100100, all other bits zero.
